// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial pattern detector between two byte requesters:
// clear the detector, stream the granted word MSB-first, wait for the count, report it.
module seq_det_sched #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int DET_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_det_clr,
  output logic              o_det_bit,
  input  logic [CNT_W-1:0]  i_det_cnt,
  input  logic              i_det_of,
  output logic              o_res_valid,
  output logic              o_res_id,
  output logic [CNT_W-1:0]  o_res_cnt,
  output logic              o_res_of,
  input  logic              i_res_ready,
  output logic              o_busy
);

  localparam int CW = $clog2(DATA_W + DET_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_WAIT,
    ST_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_id_q, last_id_d;
  logic               res_id_q, res_id_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               res_of_q, res_of_d;
  logic               gnt0, gnt1;

  // last_id_q holds the most recently served requester; its reset value of 1 favours req0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      last_id_q <= 1'b1;
      res_id_q  <= 1'b0;
      res_cnt_q <= '0;
      res_of_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      last_id_q <= last_id_d;
      res_id_q  <= res_id_d;
      res_cnt_q <= res_cnt_d;
      res_of_q  <= res_of_d;
    end
  end

  always_comb begin
    gnt1 = i_req1_valid && (!i_req0_valid || !last_id_q);
    gnt0 = i_req0_valid && !gnt1;
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    last_id_d = last_id_q;
    res_id_d  = res_id_q;
    res_cnt_d = res_cnt_q;
    res_of_d  = res_of_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          sreg_d   = gnt1 ? i_req1_data : i_req0_data;
          res_id_d = gnt1;
          cnt_d    = '0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
        if (cnt_q == CW'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(DET_LAT - 1)) begin
          res_cnt_d = i_det_cnt;
          res_of_d  = i_det_of;
          cnt_d     = '0;
          state_d   = ST_REPORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        if (i_res_ready) begin
          last_id_d = res_id_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Idle level of 1 can never start a match, since the pattern begins with 0.
  always_comb begin
    o_req0_ready = (state_q == ST_IDLE) && gnt0;
    o_req1_ready = (state_q == ST_IDLE) && gnt1;
    o_det_clr    = (state_q == ST_CLEAR);
    o_det_bit    = (state_q == ST_SHIFT) ? sreg_q[DATA_W-1] : 1'b1;
    o_res_valid  = (state_q == ST_REPORT);
    o_res_id     = res_id_q;
    o_res_cnt    = res_cnt_q;
    o_res_of     = res_of_q;
    o_busy       = (state_q != ST_IDLE);
  end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
Scheduler that shares one serial pattern-detector/event-counter datapath between two byte requesters.
- Arbitrates between the requesters round-robin.
- Clears the detector, then streams the granted byte MSB-first into the detector's serial input.
- Waits for the count to settle, then returns the captured count and overflow flag, tagged with the requester ID, over a valid/ready result port.
- Sits between the host-side byte sources and the detector/counter datapath.

Parameters:
DATA_W, 8, bits per request word; serialised MSB-first.
CNT_W, 8, width of the detector count returned by the datapath.
DET_LAT, 1, cycles from the last serial bit to a valid count; legal range 1..15.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous active-high reset.
i_req0_valid  input  1  requester 0 has a word.
i_req0_data  input  DATA_W  requester 0 word.
o_req0_ready  output  1  requester 0 word accepted this cycle when valid.
i_req1_valid  input  1  requester 1 has a word.
i_req1_data  input  DATA_W  requester 1 word.
o_req1_ready  output  1  requester 1 word accepted this cycle when valid.
o_det_clr  output  1  one-cycle synchronous clear to the detector FSM and counter.
o_det_bit  output  1  serial bit to the detector.
i_det_cnt  input  CNT_W  detector event count.
i_det_of  input  1  detector overflow flag.
o_res_valid  output  1  result available.
o_res_id  output  1  requester that owns the result.
o_res_cnt  output  CNT_W  captured count.
o_res_of  output  1  captured overflow.
i_res_ready  input  1  result consumer ready.
o_busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values:
  - State = IDLE; round-robin pointer favours req0.
  - o_det_clr=0, o_det_bit=1, o_res_valid=0, o_res_id=0, o_res_cnt=0, o_res_of=0, o_busy=0.
  - Shift register and counters cleared.
- States: IDLE, CLEAR, SHIFT, WAIT, REPORT.
- IDLE, arbitration (combinational):
  - grant = the only valid requester; if both are valid, the one not served last.
  - o_reqN_ready = (state==IDLE) && grant==N. Ready may depend on valid.
  - Ready is 0 in every other state.
- IDLE, acceptance on valid&&ready:
  - Load data into the shift register, latch the ID into o_res_id.
  - Go to CLEAR.
- CLEAR: o_det_clr=1 for exactly one cycle, o_det_bit=1. Go to SHIFT.
- SHIFT:
  - o_det_bit = shift register MSB; shift left each cycle.
  - Exactly DATA_W cycles, then go to WAIT.
- WAIT:
  - DET_LAT cycles, o_det_bit=1.
  - On the final WAIT edge, register i_det_cnt into o_res_cnt and i_det_of into o_res_of.
  - Go to REPORT.
- REPORT:
  - o_res_valid=1; o_res_id, o_res_cnt and o_res_of held stable until i_res_ready.
  - On the handshake: set the pointer to the served ID, go to IDLE.
  - A new request can be accepted in the cycle after the handshake, not the same cycle.
- Outside SHIFT, o_det_bit idles at 1. The pattern starts with 0, so idle never begins a match.
- Latency, with acceptance in cycle T:
  - o_det_clr in T+1.
  - Bits in T+2..T+1+DATA_W.
  - o_res_valid first high in T+2+DATA_W+DET_LAT (T+11 at defaults).
- Result backpressure: stalls indefinitely in REPORT. Requesters see ready=0 throughout.
- Request data changing after acceptance has no effect.
- Overflow: i_det_of is passed through as captured. No saturation or wrap handling inside this block.
- Reset mid-operation (any state): return to reset values immediately. The in-flight word and result are dropped; no o_det_clr is issued.
- A requester dropping valid in IDLE before ready goes high is legal. Arbitration re-evaluates every cycle.

Test Plan:
The bench detector model detects pattern 0101, non-overlapping, and increments its count on the edge that samples the final 1.
1. After reset, req0 sends 0x55 -> o_req0_ready high in T; o_det_clr in T+1; bits 0,1,0,1,0,1,0,1 in T+2..T+9; o_res_valid at T+11 with id=0, cnt=2, of=0.
2. req0 and req1 assert valid in the same cycle (0x00 and 0x5A) -> req0 granted first (cnt=0); after its result handshake, req1 is granted (cnt=1, id=1). A repeat with both valid -> req1 is not favoured again; req0 wins only if req1 was served last.
3. Hold i_res_ready=0 for 20 cycles in REPORT -> outputs stable, both readies 0; i_res_ready=1 -> IDLE next cycle, then the next accept.
4. Model forces i_det_cnt=0xFF and i_det_of=1 -> result cnt=0xFF, of=1.
5. Assert i_rst during SHIFT (cycle T+5) -> immediately o_busy=0, o_det_bit=1, o_res_valid=0; after release a new 0x55 gives cnt=2.
6. DET_LAT=3 build -> o_res_valid first at T+13.
